ring_count_checker: RTL and testbench
=====================================

Name: ring_count_checker

Overview:
- Receive-side monitor for a one-hot ring counter bus.
- Samples the WIDTH-bit one-hot count every clock and decodes it to a binary index.
- Checks that each sample is the left-rotation of the previous one, and locks onto a valid sequence.
- Flags and counts sequence errors. Sits downstream of any ring counter that shifts once per clk.

Parameters:
WIDTH, 4, ring width (number of one-hot bits), >=2
IDX_W, 2, index width, must equal ceil(log2(WIDTH))
LOCK_CNT, 2, consecutive good transitions required to enter LOCKED
UNLOCK_ERRS, 2, consecutive bad transitions in LOCKED that drop to SEARCH
ERR_CNT_W, 8, error counter width

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
count_in  input  WIDTH  one-hot ring count, advances every clk
index  output  IDX_W  binary position of the set bit in the last legal sample
onehot_ok  output  1  last sample had exactly one bit set
locked  output  1  FSM in LOCKED
err_pulse  output  1  one-cycle pulse per sequence error while LOCKED
err_count  output  ERR_CNT_W  saturating count of err_pulse events
wrap_pulse  output  1  one-cycle pulse on a good transition into 0...01 while LOCKED

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset).
- Reset values: all outputs 0. FSM = SEARCH; prev_q = 0; prev_valid = 0; good_run = 0; bad_run = 0.
- Latency: all outputs are registered and reflect the count_in sampled at edge k from edge k (visible in cycle k+1).
- Rotation direction: left. Expected next value is exp = {prev_q[WIDTH-2:0], prev_q[WIDTH-1]}; e.g. 0001 -> 0010 -> 0100 -> 1000 -> 0001.
- Definitions:
  - legal = popcount(count_in) == 1.
  - good = prev_valid && legal && count_in == exp.
  - bad = !good. The first sample after reset or after an illegal sample in SEARCH is neither good nor bad.
- index updates only when legal; it holds otherwise. onehot_ok <= legal every cycle.
- SEARCH:
  - If legal: prev_q <= count_in; prev_valid <= 1.
  - If illegal: prev_valid <= 0; good_run <= 0.
  - good: good_run++. When good_run reaches LOCK_CNT, go to LOCKED with bad_run = 0.
  - bad with prev_valid: good_run <= 0.
  - No err_pulse and no err_count change in SEARCH.
- LOCKED:
  - good: prev_q <= count_in; bad_run <= 0; wrap_pulse = 1 if count_in == 1.
  - bad: flywheel, prev_q <= exp (not count_in); err_pulse = 1; err_count++ saturating at all-ones; bad_run++.
  - When bad_run reaches UNLOCK_ERRS: go to SEARCH; good_run <= 0; prev_valid <= 0.
- A single glitch therefore costs one error and no unlock when the next sample matches the flywheel.
- Illegal samples (0000, multi-hot) are bad, with index held.
- reset overrides everything in the same edge, including a mid-sequence or mid-error reset.

Optional Feature:
- Macro: RCC_LAP_COUNT_EN.
- Defined:
  - Adds output lap_count, 16 bits, reset 0.
  - Increments on every wrap_pulse; wraps 0xFFFF -> 0.
  - Cleared when LOCKED -> SEARCH.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
(WIDTH=4, LOCK_CNT=2, UNLOCK_ERRS=2.)
- Reset, then drive 0001,0010,0100,1000,0001:
  - locked=1 after the 0100 edge.
  - index = 0,1,2,3,0.
  - wrap_pulse=1 only on the final 0001.
  - err_count=0.
- LOCKED at 0010, drive 0110 then 1000:
  - One err_pulse, err_count=1, onehot_ok=0 for one cycle, index holds 1.
  - 1000 accepted as good (flywheel); locked stays 1.
- LOCKED at 0100, drive 0100, 0100:
  - Two err_pulses, err_count=2, locked=0.
  - Re-lock requires a legal sample plus 2 good transitions.
- Loop 300 times (lock sequence + one glitch): err_count saturates at 255 and holds.
- LOCKED with err_count=3, assert reset for 1 cycle:
  - Next cycle all outputs 0, locked=0.
  - The first sample after reset generates no error.
- With RCC_LAP_COUNT_EN:
  - 5 full laps give lap_count=5.
  - A forced unlock gives lap_count=0.
  - Without the macro, the bench compiles with no lap_count port.

Source files
------------

// File: rtl/ring_count_checker.sv
// Receive-side monitor for a left-rotating one-hot ring counter: decodes, locks, flags and counts sequence errors.
// Define RCC_LAP_COUNT_EN to add the 16-bit lap_count output (wraps seen while locked).
module ring_count_checker #(
    parameter int WIDTH       = 4,
    parameter int IDX_W       = 2,
    parameter int LOCK_CNT    = 2,
    parameter int UNLOCK_ERRS = 2,
    parameter int ERR_CNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     count_in,
    output logic [IDX_W-1:0]     index,
    output logic                 onehot_ok,
    output logic                 locked,
    output logic                 err_pulse,
    output logic [ERR_CNT_W-1:0] err_count,
`ifdef RCC_LAP_COUNT_EN
    output logic [15:0]          lap_count,
`endif
    output logic                 wrap_pulse
);

    localparam logic [0:0] ST_SEARCH = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    localparam int GR_W = $clog2(LOCK_CNT + 1);
    localparam int BR_W = $clog2(UNLOCK_ERRS + 1);
    localparam logic [GR_W-1:0] LOCK_CNT_V    = GR_W'(LOCK_CNT);
    localparam logic [BR_W-1:0] UNLOCK_ERRS_V = BR_W'(UNLOCK_ERRS);

    logic [0:0]           state_q, state_d;
    logic [WIDTH-1:0]     prev_q, prev_d;
    logic                 prev_valid_q, prev_valid_d;
    logic [GR_W-1:0]      good_run_q, good_run_d;
    logic [BR_W-1:0]      bad_run_q, bad_run_d;
    logic [IDX_W-1:0]     index_q, index_d;
    logic                 onehot_ok_q, onehot_ok_d;
    logic                 err_pulse_q, err_pulse_d;
    logic                 wrap_pulse_q, wrap_pulse_d;
    logic [ERR_CNT_W-1:0] err_count_q, err_count_d;
`ifdef RCC_LAP_COUNT_EN
    logic [15:0]          lap_q, lap_d;
`endif

    logic                 legal;
    logic                 good;
    logic [WIDTH-1:0]     exp_val;
    logic [IDX_W-1:0]     dec_idx;

    always_comb begin
        // NOTE: every signal assigned here gets a default first so no path can infer a latch.
        legal   = ($countones(count_in) == 1);
        exp_val = {prev_q[WIDTH-2:0], prev_q[WIDTH-1]};
        good    = prev_valid_q && legal && (count_in == exp_val);
        dec_idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (count_in[i]) dec_idx = IDX_W'(i);
        end

        state_d      = state_q;
        prev_d       = prev_q;
        prev_valid_d = prev_valid_q;
        good_run_d   = good_run_q;
        bad_run_d    = bad_run_q;
        err_count_d  = err_count_q;
        err_pulse_d  = 1'b0;
        wrap_pulse_d = 1'b0;
        onehot_ok_d  = legal;
        index_d      = legal ? dec_idx : index_q;
`ifdef RCC_LAP_COUNT_EN
        lap_d        = lap_q;
`endif

        case (state_q)
            ST_SEARCH: begin
                if (legal) begin
                    prev_d       = count_in;
                    prev_valid_d = 1'b1;
                end else begin
                    prev_valid_d = 1'b0;
                    good_run_d   = '0;
                end
                if (good) begin
                    good_run_d = good_run_q + GR_W'(1);
                    if (good_run_d == LOCK_CNT_V) begin
                        state_d   = ST_LOCKED;
                        bad_run_d = '0;
                    end
                end else if (prev_valid_q && legal) begin
                    good_run_d = '0;
                end
            end
            default: begin
                if (good) begin
                    prev_d       = count_in;
                    bad_run_d    = '0;
                    wrap_pulse_d = (count_in == WIDTH'(1));
`ifdef RCC_LAP_COUNT_EN
                    if (wrap_pulse_d) lap_d = lap_q + 16'd1;
`endif
                end else begin
                    // Flywheel: trust the expected rotation so one glitch does not derail tracking.
                    prev_d      = exp_val;
                    err_pulse_d = 1'b1;
                    if (err_count_q != '1) err_count_d = err_count_q + ERR_CNT_W'(1);
                    bad_run_d = bad_run_q + BR_W'(1);
                    if (bad_run_d == UNLOCK_ERRS_V) begin
                        state_d      = ST_SEARCH;
                        good_run_d   = '0;
                        prev_valid_d = 1'b0;
                        bad_run_d    = '0;
`ifdef RCC_LAP_COUNT_EN
                        lap_d        = '0;
`endif
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset) begin
            state_q      <= ST_SEARCH;
            prev_q       <= '0;
            prev_valid_q <= 1'b0;
            good_run_q   <= '0;
            bad_run_q    <= '0;
            index_q      <= '0;
            onehot_ok_q  <= 1'b0;
            err_pulse_q  <= 1'b0;
            wrap_pulse_q <= 1'b0;
            err_count_q  <= '0;
`ifdef RCC_LAP_COUNT_EN
            lap_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            prev_q       <= prev_d;
            prev_valid_q <= prev_valid_d;
            good_run_q   <= good_run_d;
            bad_run_q    <= bad_run_d;
            index_q      <= index_d;
            onehot_ok_q  <= onehot_ok_d;
            err_pulse_q  <= err_pulse_d;
            wrap_pulse_q <= wrap_pulse_d;
            err_count_q  <= err_count_d;
`ifdef RCC_LAP_COUNT_EN
            lap_q        <= lap_d;
`endif
        end
    end

    assign index      = index_q;
    assign onehot_ok  = onehot_ok_q;
    assign locked     = (state_q == ST_LOCKED);
    assign err_pulse  = err_pulse_q;
    assign err_count  = err_count_q;
    assign wrap_pulse = wrap_pulse_q;
`ifdef RCC_LAP_COUNT_EN
    assign lap_count  = lap_q;
`endif

endmodule

// File: tb/tb_ring_count_checker.sv
// Directed bench for ring_count_checker (WIDTH=4, LOCK_CNT=2, UNLOCK_ERRS=2); lap_count checks need RCC_LAP_COUNT_EN.
module tb_ring_count_checker;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] count_in;
    logic [1:0] index;
    logic       onehot_ok;
    logic       locked;
    logic       err_pulse;
    logic [7:0] err_count;
    logic       wrap_pulse;
`ifdef RCC_LAP_COUNT_EN
    logic [15:0] lap_count;
`endif

    int n_checks = 0;
    int n_fails  = 0;

    ring_count_checker #(
        .WIDTH(4), .IDX_W(2), .LOCK_CNT(2), .UNLOCK_ERRS(2), .ERR_CNT_W(8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .count_in   (count_in),
        .index      (index),
        .onehot_ok  (onehot_ok),
        .locked     (locked),
        .err_pulse  (err_pulse),
        .err_count  (err_count),
`ifdef RCC_LAP_COUNT_EN
        .lap_count  (lap_count),
`endif
        .wrap_pulse (wrap_pulse)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_out(input string tag, input int idx, input bit ok, input bit lk,
                             input bit ep, input int ec, input bit wp);
        check({tag, ".index"},      32'(index),      32'(idx));
        check({tag, ".onehot_ok"},  32'(onehot_ok),  32'(ok));
        check({tag, ".locked"},     32'(locked),     32'(lk));
        check({tag, ".err_pulse"},  32'(err_pulse),  32'(ep));
        check({tag, ".err_count"},  32'(err_count),  32'(ec));
        check({tag, ".wrap_pulse"}, 32'(wrap_pulse), 32'(wp));
    endtask

    // Apply one sample, let it be clocked in, then look #1 after the edge.
    task automatic drive(input logic [3:0] v);
        count_in = v;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] rotl(input logic [3:0] v);
        return {v[2:0], v[3]};
    endfunction

    initial begin
        logic [3:0] r;
        reset    = 1'b1;
        count_in = 4'b0000;
        @(posedge clk);
        @(posedge clk);
        #1;
        check_out("reset", 0, 0, 0, 0, 0, 0);
        reset = 1'b0;

        // Acquire lock on a clean sequence.
        drive(4'b0001); check_out("seq0", 0, 1, 0, 0, 0, 0);
        drive(4'b0010); check_out("seq1", 1, 1, 0, 0, 0, 0);
        drive(4'b0100); check_out("seq2", 2, 1, 1, 0, 0, 0);
        drive(4'b1000); check_out("seq3", 3, 1, 1, 0, 0, 0);
        drive(4'b0001); check_out("seq4", 0, 1, 1, 0, 0, 1);

        // Single multi-hot glitch absorbed by the flywheel.
        drive(4'b0010); check_out("g_pre",  1, 1, 1, 0, 0, 0);
        drive(4'b0110); check_out("g_bad",  1, 0, 1, 1, 1, 0);
        drive(4'b1000); check_out("g_fly",  3, 1, 1, 0, 1, 0);
        drive(4'b0001); check_out("g_wrap", 0, 1, 1, 0, 1, 1);

        // Two consecutive bad samples unlock.
        reset = 1'b1; drive(4'b0000); reset = 1'b0;
        drive(4'b0001);
        drive(4'b0010);
        drive(4'b0100); check_out("u_lock", 2, 1, 1, 0, 0, 0);
        drive(4'b0100); check_out("u_bad1", 2, 1, 1, 1, 1, 0);
        drive(4'b0100); check_out("u_bad2", 2, 1, 0, 1, 2, 0);
        drive(4'b1000); check_out("r_first", 3, 1, 0, 0, 2, 0);
        drive(4'b0001); check_out("r_good1", 0, 1, 0, 0, 2, 0);
        drive(4'b0010); check_out("r_good2", 1, 1, 1, 0, 2, 0);
        drive(4'b0000); check_out("r_zero",  1, 0, 1, 1, 3, 0);
        drive(4'b1000); check_out("r_fly",   3, 1, 1, 0, 3, 0);

        // Reset while locked with errors counted.
        reset = 1'b1;
        drive(4'b0001); check_out("rst_mid", 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        drive(4'b0100); check_out("rst_first", 2, 1, 0, 0, 0, 0);

        // Error counter saturation under repeated single glitches.
        drive(4'b1000);
        drive(4'b0001); check_out("sat_lock", 0, 1, 1, 0, 0, 0);
        r = 4'b0001;
        for (int i = 0; i < 300; i++) begin
            r = rotl(r);
            drive(4'b0000);
            if (i == 254) check("sat_reach", 32'(err_count), 32'd255);
            r = rotl(r);
            drive(r);
        end
        check("sat_hold", 32'(err_count), 32'd255);
        check("sat_locked", 32'(locked), 32'd1);
        drive(4'b1111);
        check("sat_pulse", 32'(err_pulse), 32'd1);
        check("sat_hold2", 32'(err_count), 32'd255);

`ifdef RCC_LAP_COUNT_EN
        reset = 1'b1; drive(4'b0000); reset = 1'b0;
        check("lap_reset", 32'(lap_count), 32'd0);
        drive(4'b0001);
        drive(4'b0010);
        drive(4'b0100);
        drive(4'b1000);
        for (int l = 0; l < 5; l++) begin
            drive(4'b0001);
            drive(4'b0010);
            drive(4'b0100);
            drive(4'b1000);
        end
        check("lap_five", 32'(lap_count), 32'd5);
        drive(4'b1000);
        check("lap_bad1", 32'(lap_count), 32'd5);
        drive(4'b1000);
        check("lap_unlock_lk", 32'(locked), 32'd0);
        check("lap_unlock", 32'(lap_count), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
